// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
//   Shared constants and types for the nibble-serial adder/subtractor.
//   - state_e : controller states (IDLE, ADD, DONE) with fixed encodings.
//   - NIB_W   : width of one slice handled per clock by the nibble adder.
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_adder.sv
// -----------------------------------------------------------------------------
// adder
//   4-bit ripple-carry nibble adder, purely combinational.
//   Ports:
//     r1, r2  : 4-bit addends
//     ci      : carry in
//     result  : 4-bit sum
//     carry   : carry out of bit 3
// -----------------------------------------------------------------------------
module adder (
  input  logic [3:0] r1,
  input  logic [3:0] r2,
  input  logic       ci,
  output logic [3:0] result,
  output logic       carry
);

  logic [4:0] c;

  // Explicit ripple chain: c[i] is the carry into bit i.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a value on every path
    // (defaults first), otherwise synthesis infers a latch to hold it.
    c      = '0;
    result = '0;
    c[0]   = ci;
    for (int i = 0; i < 4; i++) begin
      result[i] = r1[i] ^ r2[i] ^ c[i];
      c[i+1]    = (r1[i] & r2[i]) | (c[i] & (r1[i] ^ r2[i]));
    end
  end

  assign carry = c[4];

endmodule : adder

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. One nibble per clock is pushed
//   through a single 4-bit ripple adder, with the carry registered between
//   nibbles. Operands are latched on an accepted start; the result, carry out
//   and signed overflow are registered when the last nibble completes.
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     start      : request, accepted only in IDLE or DONE
//     op_sub     : 0 = a+b+cin, 1 = a-b (cin ignored)
//     a, b, cin  : operands, latched on accepted start
//     busy       : high while nibbles are being processed
//     done       : one-cycle pulse, result valid
//     sum        : registered result, held until the next completion
//     cout       : carry out of the top bit (for subtract: 1 = no borrow)
//     ovf        : two's-complement overflow
//   WIDTH must be a multiple of 4 and at least 4.
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // effective B: already inverted for subtract
  logic [WIDTH-1:0] acc_q, acc_d;  // nibble results collected so far
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIB_W-1:0] nib_a, nib_b, nib_res;
  logic             nib_co;
  logic             last_nib;
  logic             accept;

  // Current slice of the latched operands.
  assign nib_a    = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_b    = b_q[idx_q*NIB_W +: NIB_W];
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  adder u_adder (
    .result (nib_res),
    .carry  (nib_co),
    .r1     (nib_a),
    .r2     (nib_b),
    .ci     (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = start;
      end

      ST_ADD: begin
        acc_d[idx_q*NIB_W +: NIB_W] = nib_res;
        carry_d = nib_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          // acc_d already holds the final nibble, so the result is complete.
          sum_d   = acc_d;
          cout_d  = nib_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        accept  = start;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Subtraction is a + ~b + 1: invert B once here and force the carry-in.
    if (accept) begin
      a_d     = a;
      b_d     = op_sub ? ~b : b;
      carry_d = op_sub | cin;
      idx_d   = '0;
      state_d = ST_ADD;
    end
  end

  // Operand/accumulator registers are reset too: abort-by-reset must leave
  // no stale state visible to the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Scoreboard bench for nibble_serial_adder (WIDTH=32 and WIDTH=4 instances).
//   Stimulus pushes expected results from an arithmetic reference model; a
//   monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start, op_sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  // 4-bit instance
  logic        start4, op_sub4, cin4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op_sub4), .a(a4),
    .b(b4), .cin(cin4), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .ovf(ovf4)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q32[$];
  exp_t q4[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: true integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input logic [31:0] ai,
                                 input logic [31:0] bi, input logic ci,
                                 input logic sub);
    exp_t   r;
    longint m   = (longint'(1) << w) - 1;
    longint ua  = longint'(ai) & m;
    longint ub  = longint'(bi) & m;
    longint sa  = (ua >= (longint'(1) << (w-1))) ? ua - (m + 1) : ua;
    longint sb  = (ub >= (longint'(1) << (w-1))) ? ub - (m + 1) : ub;
    longint mx  = (longint'(1) << (w-1)) - 1;
    longint mn  = -(longint'(1) << (w-1));
    longint tot, st;
    if (sub) begin
      tot    = ua - ub;
      st     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      tot    = ua + ub + longint'(ci);
      st     = sa + sb + longint'(ci);
      r.cout = (tot > m);
    end
    r.sum = 32'(tot & m);
    r.ovf = (st > mx) || (st < mn);
    return r;
  endfunction

  // Monitor: compare on every done pulse, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL done32_unexpected: got done with empty scoreboard");
      end else begin
        e = q32.pop_front();
        check("sum32",  sum,         e.sum);
        check("cout32", 32'(cout),   32'(e.cout));
        check("ovf32",  32'(ovf),    32'(e.ovf));
        check("busy32_at_done", 32'(busy), 32'd0);
      end
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL done4_unexpected: got done with empty scoreboard");
      end else begin
        e = q4.pop_front();
        check("sum4",  32'(sum4),  e.sum);
        check("cout4", 32'(cout4), 32'(e.cout));
        check("ovf4",  32'(ovf4),  32'(e.ovf));
      end
    end
  end

  // Present one request for one cycle; returns #1 after the sampling edge.
  task automatic issue(input bit w4, input logic [31:0] ai, input logic [31:0] bi,
                       input logic ci, input logic sub, input bit expect_it);
    @(posedge clk); #1;
    if (w4) begin
      a4 = ai[3:0]; b4 = bi[3:0]; cin4 = ci; op_sub4 = sub; start4 = 1'b1;
      if (expect_it) q4.push_back(model(4, ai, bi, ci, sub));
    end else begin
      a = ai; b = bi; cin = ci; op_sub = sub; start = 1'b1;
      if (expect_it) q32.push_back(model(32, ai, bi, ci, sub));
    end
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Count cycles (cycle 1 = first after the sampling edge) until done.
  task automatic wait_done(input bit w4, input int exp_lat, input int exp_busy,
                           input string name);
    int cyc = 0;
    int bc  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((w4 ? busy4 : busy) === 1'b1) bc++;
      if ((w4 ? done4 : done) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_busy_cycles"}, bc, exp_busy);
  endtask

  initial begin
    int cyc;
    int stray;
    rst_n = 1'b0;
    start = 0; op_sub = 0; cin = 0; a = '0; b = '0;
    start4 = 0; op_sub4 = 0; cin4 = 0; a4 = '0; b4 = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  sum,       32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic add with latency and busy length
    issue(0, 32'h5, 32'h5, 0, 0, 1);
    wait_done(0, 9, 8, "t1");

    // 2: carry out and signed overflow
    issue(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 1);
    wait_done(0, 9, 8, "t2a");
    issue(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 1);
    wait_done(0, 9, 8, "t2b");

    // 3: subtract, cin ignored
    issue(0, 32'd5, 32'd7, 1, 1, 1);
    wait_done(0, 9, 8, "t3a");
    issue(0, 32'd7, 32'd5, 0, 1, 1);
    wait_done(0, 9, 8, "t3b");

    // 4: start during ADD ignored, start during DONE accepted
    issue(0, 32'h1234_5678, 32'h1111_1111, 0, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = $urandom; b = $urandom; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    for (int i = 4; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("t4_latency", cyc, 9);
    // Still in the DONE cycle: request the next operation.
    a = 32'd1; b = 32'd2; cin = 0; op_sub = 0; start = 1'b1;
    q32.push_back(model(32, 32'd1, 32'd2, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 9, 8, "t4_b2b");

    // 5: asynchronous reset mid-operation aborts with no done
    issue(0, $urandom, $urandom, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum",  sum,       32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    check("t5_no_activity", stray, 0);
    issue(0, 32'h0000_000F, 32'h0000_0001, 0, 0, 1);
    wait_done(0, 9, 8, "t5_after");

    // 6: WIDTH=4 instance
    issue(1, 32'h9, 32'h8, 1, 0, 1);
    wait_done(1, 2, 1, "t6");

    // Randomized operations on both widths
    for (int n = 0; n < 25; n++) begin
      issue(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1);
      wait_done(0, 9, 8, "rnd32");
    end
    for (int n = 0; n < 25; n++) begin
      issue(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1);
      wait_done(1, 2, 1, "rnd4");
    end

    repeat (3) @(posedge clk);
    check("q32_drained", q32.size(), 0);
    check("q4_drained",  q4.size(),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder/subtractor for the CPU datapath. It computes WIDTH-bit sums four bits per clock by reusing the team's 4-bit ripple-carry nibble adder. The carry is registered between nibbles. The block latches operands on a start/done handshake, sequences the nibble slices into the adder, and collects the nibble results and carry into a registered WIDTH-bit result for the writeback stage.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, number of nibble cycles (derived, not overridden).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE or DONE.
op_sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, carry-in forced 1, cin ignored).
a  input  WIDTH  operand A, latched on accepted start.
b  input  WIDTH  operand B, latched on accepted start.
cin  input  1  carry-in, latched on accepted start.
busy  output  1  high while nibbles are being processed.
done  output  1  one-cycle pulse: result valid.
sum  output  WIDTH  registered result; holds until the next completion.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal operand, carry and index registers = 0.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 → latch a, b_eff (b, or ~b if op_sub) and carry (cin, or 1 if op_sub).
  - Set idx=0, go to ADD. busy rises the following cycle.
- ADD:
  - Each cycle, nibble idx of a and b_eff plus the carry register feed the nibble adder.
  - The result nibble is written into the internal accumulator at position idx.
  - The adder carry-out is registered as the next carry. idx increments.
  - When idx = NIB-1: load sum from the accumulator (including the current nibble), load cout from the final carry-out, load ovf, then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1: accept as in IDLE and go to ADD.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; done is high during the cycle after edge E0+NIB. WIDTH=32 → done on the 9th cycle after start. Back-to-back throughput: one result per NIB+1 cycles.
- start while busy (ADD): ignored. Operands and op_sub changing during ADD have no effect.
- ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), using the latched operands.
- For op_sub, cout = 1 means no borrow.
- Arithmetic wraps modulo 2^WIDTH.
- idx is $clog2(NIB) bits wide, minimum 1. It resets to 0 on every accepted start.
- sum, cout and ovf change only on the ADD→DONE transition or on reset. They are stable between done pulses.

Decomposition:
- Shared package:
  - State encoding constants: ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2.
  - Nibble width constant NIB_W=4.
- One sub-module: the existing 4-bit nibble adder `adder`. Instantiate it once, combinationally, in the ADD datapath, with ports result, carry, r1, r2, ci.
- No other sub-modules.

Test Plan:
1. Reset, then a=0x00000005, b=0x00000005, cin=0, op_sub=0, start pulse → done on the 9th cycle after start; sum=0x0000000A, cout=0, ovf=0; busy high for exactly 8 cycles.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0. a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1.
3. op_sub=1, a=5, b=7, cin=1 (ignored) → sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 → sum=0x00000002, cout=1.
4. Start a=0x12345678 + b=0x11111111. Pulse start again and change a and b at cycle 3 → second start ignored; sum=0x23456789 with a single done. Assert start during the DONE cycle with a=1, b=2 → next done 9 cycles later with sum=3.
5. Assert rst_n=0 asynchronously mid-clock at cycle 4 of an ADD → all outputs 0 immediately, no done. After release, a new start completes correctly: 0x0000000F+0x00000001 = 0x00000010.
6. WIDTH=4 instance: a=0x9, b=0x8, cin=1 → done 2 cycles after start; sum=0x2, cout=1, ovf=1.
